// File: rtl/mipi_rffe_slave_pkg.sv
// RFFE slave shared definitions: field widths,
// command codes and FSM state encoding.
package mipi_rffe_slave_pkg;

  localparam int SA_W     = 4;
  localparam int C_W      = 8;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int CMD_BITS = SA_W + C_W + 1;
  localparam int DAT_BITS = DATA_W + 1;

  localparam logic [2:0] CMD_RW = 3'b010;
  localparam logic [2:0] CMD_RR = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RPARK,
    ST_RDATA,
    ST_PARK
  } state_t;

  function automatic logic odd_par(
    input logic [DATA_W-1:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/mipi_rffe_slave_edge_sync.sv
// Two-flop synchronizer for an async pin plus
// single-cycle rise/fall strobes on the synced level.
module rffe_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // sync chain; s3 holds the previous synced level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/mipi_rffe_slave.sv
// RFFE slave: command decode, register write/read,
// register-0 write, 32x8 register file.
module mipi_rffe_slave
  import mipi_rffe_slave_pkg::*;
#(
  parameter logic [SA_W-1:0] USID = 4'h0,
  parameter int              NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              sdata_in,
  output logic              sdata_out,
  output logic              sdata_oe,
  output logic              wr_vd,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              err
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic sdat_q, sdat_rise, sdat_fall;

  rffe_edge_sync u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk_in),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  rffe_edge_sync u_sdat (
    .clk  (clk),
    .rst  (rst),
    .d    (sdata_in),
    .q    (sdat_q),
    .rise (sdat_rise),
    .fall (sdat_fall)
  );

  state_t              state;
  logic [3:0]          cnt;
  logic [11:0]         sh;
  logic [ADDR_W-1:0]   addr;
  logic [DAT_BITS-1:0] rd_sh;
  logic [DATA_W-1:0]   regs [NREG];
  logic                arm;
  logic                ssc;

  logic [CMD_BITS-1:0] cmd_w;
  logic [DAT_BITS-1:0] dat_w;

  assign cmd_w = {sh, sdat_q};
  assign dat_w = {sh[7:0], sdat_q};
  assign ssc   = arm & sdat_fall & ~sclk_q;

  // SSC arm: SDATA rose while SCLK low
  always_ff @(posedge clk) begin
    if (rst)
      arm <= 1'b0;
    else if (sclk_q || ssc)
      arm <= 1'b0;
    else if (sdat_rise)
      arm <= 1'b1;
  end

  // frame FSM, register file and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sh        <= '0;
      addr      <= '0;
      rd_sh     <= '0;
      sdata_oe  <= 1'b0;
      sdata_out <= 1'b0;
      wr_vd     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      wr_vd <= 1'b0;
      err   <= 1'b0;
      if (ssc) begin
        state     <= ST_CMD;
        cnt       <= '0;
        sdata_oe  <= 1'b0;
        sdata_out <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_CMD: if (sclk_fall) begin
            sh  <= cmd_w[11:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'(CMD_BITS - 1)) begin
              cnt <= '0;
              if (cmd_w[12:9] != USID)
                state <= ST_IDLE;
              else if (!(^cmd_w)) begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end else if (cmd_w[8]) begin
                regs[0] <= {1'b0, cmd_w[7:1]};
                wr_vd   <= 1'b1;
                wr_addr <= '0;
                wr_data <= {1'b0, cmd_w[7:1]};
                state   <= ST_PARK;
              end else if (cmd_w[8:6] == CMD_RW) begin
                addr  <= cmd_w[5:1];
                state <= ST_WDATA;
              end else if (cmd_w[8:6] == CMD_RR) begin
                addr  <= cmd_w[5:1];
                state <= ST_RPARK;
              end else
                state <= ST_PARK;
            end
          end
          ST_WDATA: if (sclk_fall) begin
            sh  <= cmd_w[11:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'(DAT_BITS - 1)) begin
              cnt <= '0;
              if (^dat_w) begin
                regs[addr] <= dat_w[8:1];
                wr_vd      <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= dat_w[8:1];
                state      <= ST_PARK;
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
          ST_RPARK: if (sclk_fall) begin
            cnt   <= '0;
            rd_sh <= {regs[addr], odd_par(regs[addr])};
            state <= ST_RDATA;
          end
          ST_RDATA: begin
            if (sclk_rise && cnt < 4'(DAT_BITS)) begin
              sdata_oe  <= 1'b1;
              sdata_out <= rd_sh[DAT_BITS-1];
              rd_sh     <= {rd_sh[DAT_BITS-2:0], 1'b0};
              cnt       <= cnt + 4'd1;
            end else if (sclk_fall && cnt == 4'(DAT_BITS)) begin
              cnt   <= '0;
              state <= ST_PARK;
            end
          end
          ST_PARK: begin
            if (!sdata_oe)
              state <= ST_IDLE;
            else if (sclk_rise) begin
              sdata_out <= 1'b0;
              cnt       <= 4'd1;
            end else if (sclk_fall && cnt == 4'd1) begin
              sdata_oe <= 1'b0;
              cnt      <= '0;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mipi_rffe_slave.sv
// Directed bench for mipi_rffe_slave (USID=A):
// write, read, reg-0 write, parity error, SA miss, reset.
module tb_mipi_rffe_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk_in = 1'b0;
  logic       sdata_in = 1'b0;
  logic       sdata_out, sdata_oe, wr_vd, err;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int vec = 0;
  int miss = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;
  logic [4:0] last_addr = '0;
  logic [7:0] last_data = '0;

  mipi_rffe_slave #(.USID(4'hA), .NREG(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .sdata_in  (sdata_in),
    .sdata_out (sdata_out),
    .sdata_oe  (sdata_oe),
    .wr_vd     (wr_vd),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_vd) begin
        wr_cnt    <= wr_cnt + 1;
        last_addr <= wr_addr;
        last_data <= wr_data;
      end
      if (err) err_cnt <= err_cnt + 1;
      if (sdata_oe) oe_cnt <= oe_cnt + 1;
    end
  end

  task automatic ssc();
    sdata_in = 1'b0; #40;
    sdata_in = 1'b1; #40;
    sdata_in = 1'b0; #40;
  endtask

  task automatic send_bit(input logic b);
    sclk_in = 1'b1; #10;
    sdata_in = b; #30;
    sclk_in = 1'b0; #40;
  endtask

  task automatic send_cmd(input logic [3:0] sa, input logic [7:0] c);
    logic [12:0] v;
    v = {sa, c, ~^{sa, c}};
    for (int i = 12; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_write(input logic [3:0] sa, input logic [4:0] a,
                          input logic [7:0] d, input logic flip,
                          input logic park);
    logic [8:0] v;
    ssc();
    send_cmd(sa, {3'b010, a});
    v = {d, (~^d) ^ flip};
    for (int i = 8; i >= 0; i--) send_bit(v[i]);
    if (park) send_bit(1'b0);
    #40;
  endtask

  task automatic do_read(input logic [3:0] sa, input logic [4:0] a,
                         output logic [7:0] d, output logic p,
                         output logic [8:0] oeb, output logic rp_oe,
                         output logic pk_oe, output logic pk_out,
                         output logic rel_oe);
    d = '0;
    p = 1'b0;
    ssc();
    send_cmd(sa, {3'b011, a});
    sclk_in = 1'b1; #10;
    sdata_in = 1'b0; #30;
    rp_oe = sdata_oe;
    sclk_in = 1'b0; #40;
    for (int i = 8; i >= 0; i--) begin
      sclk_in = 1'b1; #40;
      oeb[i] = sdata_oe;
      if (i > 0) d[i-1] = sdata_out;
      else p = sdata_out;
      sclk_in = 1'b0; #40;
    end
    sclk_in = 1'b1; #40;
    pk_oe = sdata_oe;
    pk_out = sdata_out;
    sclk_in = 1'b0; #40;
    rel_oe = sdata_oe;
    #40;
  endtask

  task automatic test_reset();
    rst = 1'b1; #30;
    vec++; if (sdata_oe !== 1'b0) begin miss++; $display("FAIL rst_oe got %b exp 0", sdata_oe); end
    vec++; if (sdata_out !== 1'b0) begin miss++; $display("FAIL rst_out got %b exp 0", sdata_out); end
    vec++; if (wr_vd !== 1'b0) begin miss++; $display("FAIL rst_wr_vd got %b exp 0", wr_vd); end
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp 0", err); end
    vec++; if (wr_addr !== 5'h00) begin miss++; $display("FAIL rst_wr_addr got %h exp 00", wr_addr); end
    vec++; if (wr_data !== 8'h00) begin miss++; $display("FAIL rst_wr_data got %h exp 00", wr_data); end
    rst = 1'b0; #40;
  endtask

  task automatic test_write();
    int w0, e0, o0;
    w0 = wr_cnt; e0 = err_cnt; o0 = oe_cnt;
    do_write(4'hA, 5'h05, 8'h3C, 1'b0, 1'b1);
    vec++; if (wr_cnt - w0 != 1) begin miss++; $display("FAIL wr_count got %0d exp 1", wr_cnt - w0); end
    vec++; if (last_addr !== 5'h05) begin miss++; $display("FAIL wr_addr got %h exp 05", last_addr); end
    vec++; if (last_data !== 8'h3C) begin miss++; $display("FAIL wr_data got %h exp 3c", last_data); end
    vec++; if (err_cnt != e0) begin miss++; $display("FAIL wr_err got %0d exp 0", err_cnt - e0); end
    vec++; if (oe_cnt != o0) begin miss++; $display("FAIL wr_oe got %0d exp 0", oe_cnt - o0); end
  endtask

  task automatic test_read();
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    do_read(4'hA, 5'h05, d, p, ob, rp, po, pd, ro);
    vec++; if (d !== 8'h3C) begin miss++; $display("FAIL rd_data got %h exp 3c", d); end
    vec++; if (p !== 1'b1) begin miss++; $display("FAIL rd_par got %b exp 1", p); end
    vec++; if (ob !== 9'h1FF) begin miss++; $display("FAIL rd_oe got %b exp 111111111", ob); end
    vec++; if (rp !== 1'b0) begin miss++; $display("FAIL rpark_oe got %b exp 0", rp); end
    vec++; if ({po, pd} !== 2'b10) begin miss++; $display("FAIL park_oe_out got %b exp 10", {po, pd}); end
    vec++; if (ro !== 1'b0) begin miss++; $display("FAIL rel_oe got %b exp 0", ro); end
  endtask

  task automatic test_reg0();
    int w0;
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    w0 = wr_cnt;
    ssc();
    send_cmd(4'hA, 8'hD5);
    send_bit(1'b0);
    #40;
    vec++; if (wr_cnt - w0 != 1) begin miss++; $display("FAIL r0_count got %0d exp 1", wr_cnt - w0); end
    vec++; if (last_addr !== 5'h00) begin miss++; $display("FAIL r0_addr got %h exp 00", last_addr); end
    vec++; if (last_data !== 8'h55) begin miss++; $display("FAIL r0_data got %h exp 55", last_data); end
    do_read(4'hA, 5'h00, d, p, ob, rp, po, pd, ro);
    vec++; if (d !== 8'h55) begin miss++; $display("FAIL r0_rd got %h exp 55", d); end
    vec++; if (p !== 1'b1) begin miss++; $display("FAIL r0_par got %b exp 1", p); end
  endtask

  task automatic test_parity_err();
    int w0, e0;
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    w0 = wr_cnt; e0 = err_cnt;
    do_write(4'hA, 5'h05, 8'h99, 1'b1, 1'b1);
    vec++; if (err_cnt - e0 != 1) begin miss++; $display("FAIL perr_err got %0d exp 1", err_cnt - e0); end
    vec++; if (wr_cnt != w0) begin miss++; $display("FAIL perr_wr got %0d exp 0", wr_cnt - w0); end
    do_read(4'hA, 5'h05, d, p, ob, rp, po, pd, ro);
    vec++; if (d !== 8'h3C) begin miss++; $display("FAIL perr_rd got %h exp 3c", d); end
  endtask

  task automatic test_sa_mismatch();
    int w0, e0, o0;
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    w0 = wr_cnt; e0 = err_cnt; o0 = oe_cnt;
    do_write(4'h3, 5'h05, 8'h11, 1'b0, 1'b1);
    do_read(4'h3, 5'h05, d, p, ob, rp, po, pd, ro);
    vec++; if (wr_cnt != w0) begin miss++; $display("FAIL sa_wr got %0d exp 0", wr_cnt - w0); end
    vec++; if (err_cnt != e0) begin miss++; $display("FAIL sa_err got %0d exp 0", err_cnt - e0); end
    vec++; if (oe_cnt != o0) begin miss++; $display("FAIL sa_oe got %0d exp 0", oe_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    w0 = wr_cnt;
    do_write(4'hA, 5'h1F, 8'hA5, 1'b0, 1'b0);
    do_write(4'hA, 5'h02, 8'h07, 1'b0, 1'b1);
    vec++; if (wr_cnt - w0 != 2) begin miss++; $display("FAIL b2b_count got %0d exp 2", wr_cnt - w0); end
    vec++; if (last_data !== 8'h07) begin miss++; $display("FAIL b2b_last got %h exp 07", last_data); end
    do_read(4'hA, 5'h1F, d, p, ob, rp, po, pd, ro);
    vec++; if ({d, p} !== {8'hA5, 1'b1}) begin miss++; $display("FAIL b2b_rd1f got %h/%b exp a5/1", d, p); end
    do_read(4'hA, 5'h02, d, p, ob, rp, po, pd, ro);
    vec++; if ({d, p} !== {8'h07, 1'b0}) begin miss++; $display("FAIL b2b_rd02 got %h/%b exp 07/0", d, p); end
  endtask

  task automatic test_rst_mid_read();
    int w0;
    logic o1, o2, out2;
    logic [7:0] d;
    logic p, rp, po, pd, ro;
    logic [8:0] ob;
    logic [4:0] al [4];
    al[0] = 5'h05; al[1] = 5'h00; al[2] = 5'h1F; al[3] = 5'h02;
    w0 = wr_cnt;
    ssc();
    send_cmd(4'hA, 8'h65);
    sclk_in = 1'b1; #10;
    sdata_in = 1'b0; #30;
    sclk_in = 1'b0; #40;
    for (int i = 0; i < 4; i++) begin
      sclk_in = 1'b1; #40;
      sclk_in = 1'b0; #40;
    end
    sclk_in = 1'b1; #40;
    o1 = sdata_oe;
    rst = 1'b1; #10;
    o2 = sdata_oe;
    out2 = sdata_out;
    #20;
    rst = 1'b0;
    sclk_in = 1'b0; #80;
    vec++; if (o1 !== 1'b1) begin miss++; $display("FAIL mid_oe_before got %b exp 1", o1); end
    vec++; if (o2 !== 1'b0) begin miss++; $display("FAIL mid_oe_after got %b exp 0", o2); end
    vec++; if (out2 !== 1'b0) begin miss++; $display("FAIL mid_out_after got %b exp 0", out2); end
    vec++; if (wr_cnt != w0) begin miss++; $display("FAIL mid_wr got %0d exp 0", wr_cnt - w0); end
    for (int k = 0; k < 4; k++) begin
      do_read(4'hA, al[k], d, p, ob, rp, po, pd, ro);
      vec++; if ({d, p} !== {8'h00, 1'b1}) begin miss++; $display("FAIL mid_clr_%h got %h/%b exp 00/1", al[k], d, p); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reg0();
    test_parity_err();
    test_sa_mismatch();
    test_back_to_back();
    test_rst_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mipi_rffe_slave.md
MIPI_RFFE_SLAVE -- requirements
Module: mipi_rffe_slave

Interface
REQ-001 Parameter USID, 4'h0: unique slave ID matched against the SA field.
REQ-002 Parameter NREG, 32: register-file depth, fixed to the 5-bit register address space.
REQ-003 clk  in  1: single system clock, at least 4x SCLK; all logic on posedge clk.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 sclk_in  in  1: RFFE SCLK from master, asynchronous to clk.
REQ-006 sdata_in  in  1: RFFE SDATA from master, asynchronous to clk.
REQ-007 sdata_out  out  1: slave SDATA drive value.
REQ-008 sdata_oe  out  1: slave SDATA output enable; the pad tri-states when low.
REQ-009 wr_vd  out  1: one-clk pulse on each committed register write.
REQ-010 wr_addr  out  5: address of the committed write; valid with wr_vd.
REQ-011 wr_data  out  8: data of the committed write; valid with wr_vd.
REQ-012 err  out  1: one-clk pulse on a parity error.

Function
REQ-013 sclk_in and sdata_in SHALL pass a 2-FF synchronizer, then edge detection; the sampling point is the detected SCLK falling edge.
REQ-014 SSC SHALL be detected as an SDATA rising then falling edge while synchronized SCLK is low, from IDLE; any SSC SHALL restart frame reception.
REQ-015 Command frame: SA[3:0], C[7:0], P, MSB first, 13 falling edges.
REQ-016 Parity SHALL be odd across each frame, data bits plus P.
REQ-017 States: IDLE, CMD, WDATA, RPARK, RDATA, PARK.
REQ-018 IDLE: wait for SSC, then go to CMD with the bit counter cleared.
REQ-019 CMD: on the 13th bit, check parity and SA against USID, then decode C:
- C[7:5]=010: Register Write -> WDATA.
- C[7:5]=011: Register Read -> RPARK.
- C[7]=1: Register-0 Write, with data C[6:0] zero-extended.
- Any other C: PARK with no action.
REQ-020 SA mismatch SHALL go to IDLE silently, with no err and no drive.
REQ-021 Parity failure in any frame SHALL pulse err, suppress the write, and go to IDLE.
REQ-022 WDATA: receive 8 data bits plus P (9 falling edges); on good parity, write reg[C[4:0]] and pulse wr_vd/wr_addr/wr_data on the clk after the parity bit; then PARK.
REQ-023 Register-0 Write SHALL commit and pulse wr_vd in the clk after the command parity bit.
REQ-024 RPARK: wait one SCLK period; sdata_oe SHALL stay low.
REQ-025 RDATA: on each synchronized SCLK rising edge, drive the next bit of reg[addr] MSB first, then an odd-parity bit.
- sdata_oe SHALL be high from the first data rising edge until the falling edge after P.
REQ-026 PARK (bus park): drive 0 for one SCLK rising-to-falling span after read data, then release sdata_oe and go to IDLE; after writes, go straight to IDLE.
REQ-027 If a write commit and a new SSC coincide, the commit SHALL complete first.
REQ-028 The register file SHALL be written only by this block; write on the same clk as wr_vd.
REQ-029 Latency: wr_vd at most 1 clk after the parity-bit falling edge is detected; total at most 4 clk from the pin edge.

Reset
REQ-030 On rst: state=IDLE, counters=0, sdata_oe=0, sdata_out=0, wr_vd=0, err=0, wr_addr=0, wr_data=0.
REQ-031 On rst: all registers=8'h00 and synchronizers cleared.
REQ-032 rst mid-frame SHALL abort with no write, and release SDATA the next clk.

Structure
REQ-033 RFFE command codes, field widths (SA=4, C=8, ADDR=5, DATA=8) and state encodings SHALL live in globals.v.
REQ-034 A single sub-module rffe_edge_sync SHALL hold the 2-FF synchronizer plus rise/fall detect, instantiated once each for SCLK and SDATA.
REQ-035 Target size: 120-400 lines of RTL.

Verification
REQ-036 USID=4'hA; SSC, then Register Write addr 5'h05, data 8'h3C, good parity -> wr_vd once, wr_addr=5'h05, wr_data=8'h3C.
REQ-037 Register Read addr 5'h05 after REQ-036 -> slave drives 0011_1100 then P=1; sdata_oe released after park.
REQ-038 Register-0 Write C=8'hD5 -> reg0=8'h55 and wr_vd with wr_addr=0; a following read of addr 0 returns 8'h55.
REQ-039 Register Write with the data-frame parity bit flipped -> err pulse, no wr_vd, and a subsequent read returns the old value.
REQ-040 SA=4'h3 with USID=4'hA -> no wr_vd, no err, sdata_oe never high.
REQ-041 rst asserted during RDATA bit 4 -> sdata_oe=0 the next clk, state IDLE, all registers 8'h00.
